// File: rtl/sha2_pkg.sv
// rtl/sha2_pkg.sv - SHA-2 state bank constants, IV sets, FSM state type
package sha2_pkg;

    localparam int NUM_WORDS = 8;

    // SHA-256 / SHA-224 initial hash values, H0 in the MSBs
    localparam logic [255:0] IV_SHA256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [255:0] IV_SHA224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    // SHA-512 / SHA-384 initial hash values, H0 in the MSBs
    localparam logic [511:0] IV_SHA512 = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };
    localparam logic [511:0] IV_SHA384 = {
        64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
        64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4
    };

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ROUND,
        FEEDFWD
    } state_t;

    // IV for the word width and truncation mode; 32-bit sets sit in the low 256 bits
    function automatic logic [511:0] sha2_iv(input int word_w, input logic trunc);
        if (word_w == 64) begin
            return trunc ? IV_SHA384 : IV_SHA512;
        end
        return {256'd0, (trunc ? IV_SHA224 : IV_SHA256)};
    endfunction

endpackage

// File: rtl/sha2_feedfwd_add.sv
// rtl/sha2_feedfwd_add.sv - eight independent modular adders forming the next chaining value
module sha2_feedfwd_add
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic [NUM_WORDS*WORD_W-1:0] h,
    input  logic [NUM_WORDS*WORD_W-1:0] work,
    output logic [NUM_WORDS*WORD_W-1:0] h_next
);

    // Each word wraps on its own; no carry crosses a word boundary
    for (genvar i = 0; i < NUM_WORDS; i++) begin : g_add
        assign h_next[i*WORD_W +: WORD_W] = h[i*WORD_W +: WORD_W] + work[i*WORD_W +: WORD_W];
    end

endmodule

// File: rtl/sha2_state_bank.sv
// rtl/sha2_state_bank.sv - SHA-2 chaining/working register bank and block sequencer (option: SHA2_TRUNC_EN)
module sha2_state_bank
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64,
    parameter int CNT_W  = $clog2(ROUNDS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef SHA2_TRUNC_EN
    input  logic                        mode_trunc,
`endif
    input  logic                        start_msg,
    input  logic                        start_blk,
    input  logic                        abort,
    input  logic                        round_valid,
    input  logic [NUM_WORDS*WORD_W-1:0] work_in,
    output logic [NUM_WORDS*WORD_W-1:0] work_out,
    output logic [CNT_W-1:0]            round_cnt,
    output logic                        busy,
    output logic                        blk_done,
    output logic                        digest_valid,
    output logic [NUM_WORDS*WORD_W-1:0] digest_out
);

    localparam int DW = NUM_WORDS * WORD_W;

    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
        $error("sha2_state_bank: WORD_W must be 32 or 64");
    end

    localparam logic [511:0]   IV_FULL_W = sha2_iv(WORD_W, 1'b0);
    localparam logic [DW-1:0]  IV_FULL   = IV_FULL_W[DW-1:0];

    state_t          state_q, state_d;
    logic [DW-1:0]   h_q, work_q, h_next, start_iv;
    logic [CNT_W-1:0] cnt_q;
    logic            blk_done_q, digest_valid_q, chain_valid_q;
    logic            load_iv, load_chain, take_round, do_ff, do_abort;

`ifdef SHA2_TRUNC_EN
    localparam logic [511:0]  IV_TRUNC_W = sha2_iv(WORD_W, 1'b1);
    localparam logic [DW-1:0] IV_TRUNC   = IV_TRUNC_W[DW-1:0];
    // SHA-224 drops H7, SHA-384 drops H6..H7
    localparam int            ZW         = (WORD_W == 64) ? 2 * WORD_W : WORD_W;
    localparam logic [DW-1:0] TRUNC_MASK = {{(DW - ZW){1'b1}}, {ZW{1'b0}}};
    logic trunc_q;

    assign start_iv   = mode_trunc ? IV_TRUNC : IV_FULL;
    assign digest_out = trunc_q ? (h_q & TRUNC_MASK) : h_q;
`else
    assign start_iv   = IV_FULL;
    assign digest_out = h_q;
`endif

    assign work_out     = work_q;
    assign round_cnt    = cnt_q;
    assign busy         = (state_q != IDLE);
    assign blk_done     = blk_done_q;
    assign digest_valid = digest_valid_q;

    sha2_feedfwd_add #(
        .WORD_W (WORD_W)
    ) u_feedfwd (
        .h      (h_q),
        .work   (work_q),
        .h_next (h_next)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle datapath actions
    always_comb begin
        state_d    = state_q;
        load_iv    = 1'b0;
        load_chain = 1'b0;
        take_round = 1'b0;
        do_ff      = 1'b0;
        do_abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_msg || start_blk) begin
                    if (abort) begin
                        // Start cancelled in the same cycle: spend one cycle and load nothing
                        state_d = LOAD;
                    end else begin
                        if (start_msg || !chain_valid_q) begin
                            load_iv = 1'b1;
                        end else begin
                            load_chain = 1'b1;
                        end
                        state_d = ROUND;
                    end
                end
            end
            LOAD: begin
                do_abort = abort;
                state_d  = IDLE;
            end
            ROUND: begin
                if (abort) begin
                    do_abort = 1'b1;
                    state_d  = IDLE;
                end else if (round_valid) begin
                    take_round = 1'b1;
                    if (cnt_q == CNT_W'(ROUNDS - 1)) begin
                        state_d = FEEDFWD;
                    end
                end
            end
            FEEDFWD: begin
                if (abort) begin
                    do_abort = 1'b1;
                end else begin
                    do_ff = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Chaining value, working variables, round counter and status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q            <= IV_FULL;
            work_q         <= IV_FULL;
            cnt_q          <= '0;
            blk_done_q     <= 1'b0;
            digest_valid_q <= 1'b0;
            chain_valid_q  <= 1'b0;
`ifdef SHA2_TRUNC_EN
            trunc_q        <= 1'b0;
`endif
        end else begin
            blk_done_q <= do_ff;
            if (load_iv) begin
                h_q            <= start_iv;
                work_q         <= start_iv;
                chain_valid_q  <= 1'b1;
                digest_valid_q <= 1'b0;
`ifdef SHA2_TRUNC_EN
                trunc_q        <= mode_trunc;
`endif
            end
            if (load_chain) begin
                work_q         <= h_q;
                digest_valid_q <= 1'b0;
            end
            if (take_round) begin
                work_q <= work_in;
                cnt_q  <= cnt_q + CNT_W'(1);
            end
            if (do_ff) begin
                h_q            <= h_next;
                digest_valid_q <= 1'b1;
                cnt_q          <= '0;
            end
            if (do_abort) begin
                cnt_q          <= '0;
                chain_valid_q  <= 1'b0;
                digest_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sha2_state_bank.sv
// tb/tb_sha2_state_bank.sv - directed self-checking bench for sha2_state_bank (32- and 64-bit instances)
module tb_sha2_state_bank;

    localparam logic [255:0] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [255:0] ABC_WORK = {
        32'h506e3058, 32'hd39a2165, 32'h04d24d6c, 32'hb85e2ce9,
        32'h5ef50f24, 32'hfb121210, 32'h948d25b6, 32'h961f4894
    };
    localparam logic [255:0] ABC_DIGEST = {
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
    };
    localparam logic [511:0] IV512 = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };
    localparam logic [511:0] IV512_P1 = {
        64'h6a09e667f3bcc909, 64'hbb67ae8584caa73c, 64'h3c6ef372fe94f82c, 64'ha54ff53a5f1d36f2,
        64'h510e527fade682d2, 64'h9b05688c2b3e6c20, 64'h1f83d9abfb41bd6c, 64'h5be0cd19137e217a
    };

    logic         clk = 1'b0;
    logic         rst_n;

    logic         s_msg, s_blk, s_abort, s_rv;
    logic [255:0] s_win, s_wout, s_dig;
    logic [6:0]   s_cnt;
    logic         s_busy, s_done, s_dv;

    logic         q_msg, q_blk, q_abort, q_rv;
    logic [511:0] q_win, q_wout, q_dig;
    logic [6:0]   q_cnt;
    logic         q_busy, q_done, q_dv;

    int tests = 0;
    int fails = 0;
    int done_seen;
    logic [255:0] pat_a, pat_b;
    logic [511:0] w5;

    always #5 clk = ~clk;

    sha2_state_bank #(.WORD_W(32), .ROUNDS(64)) u_dut32 (
        .clk          (clk),
        .rst          (rst_n),
`ifdef SHA2_TRUNC_EN
        .mode_trunc   (1'b0),
`endif
        .start_msg    (s_msg),
        .start_blk    (s_blk),
        .abort        (s_abort),
        .round_valid  (s_rv),
        .work_in      (s_win),
        .work_out     (s_wout),
        .round_cnt    (s_cnt),
        .busy         (s_busy),
        .blk_done     (s_done),
        .digest_valid (s_dv),
        .digest_out   (s_dig)
    );

    sha2_state_bank #(.WORD_W(64), .ROUNDS(80)) u_dut64 (
        .clk          (clk),
        .rst          (rst_n),
`ifdef SHA2_TRUNC_EN
        .mode_trunc   (1'b0),
`endif
        .start_msg    (q_msg),
        .start_blk    (q_blk),
        .abort        (q_abort),
        .round_valid  (q_rv),
        .work_in      (q_win),
        .work_out     (q_wout),
        .round_cnt    (q_cnt),
        .busy         (q_busy),
        .blk_done     (q_done),
        .digest_valid (q_dv),
        .digest_out   (q_dig)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        s_msg = 0; s_blk = 0; s_abort = 0; s_rv = 0; s_win = '0;
        q_msg = 0; q_blk = 0; q_abort = 0; q_rv = 0; q_win = '0;
        pat_a = {8{32'h00000011}};
        pat_b = {8{32'hdeadbeef}};
        w5    = {8{64'h0123456789abcdef}};
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_digest32", s_dig, IV256);
        check("rst_work32", s_wout, IV256);
        check("rst_dv32", s_dv, 0);
        check("rst_busy32", s_busy, 0);
        check("rst_cnt32", s_cnt, 0);
        check("rst_h0_64", q_dig[511:448], 64'h6a09e667f3bcc908);

        // round_valid while idle is ignored
        s_rv = 1; s_win = pat_b;
        tick();
        s_rv = 0;
        check("idle_rv_work", s_wout, IV256);
        check("idle_rv_cnt", s_cnt, 0);

        // "abc" block
        s_msg = 1;
        tick();
        s_msg = 0;
        check("msg_load_work", s_wout, IV256);
        check("msg_busy", s_busy, 1);
        for (int i = 0; i < 64; i++) begin
            s_rv  = 1;
            s_win = (i == 63) ? ABC_WORK : {8{i[31:0]}};
            tick();
        end
        s_rv = 0;
        check("abc_ff_cnt", s_cnt, 64);
        check("abc_ff_busy", s_busy, 1);
        check("abc_ff_done", s_done, 0);
        tick();
        check("abc_done", s_done, 1);
        check("abc_digest", s_dig, ABC_DIGEST);
        check("abc_dv", s_dv, 1);
        check("abc_cnt0", s_cnt, 0);
        check("abc_idle", s_busy, 0);
        tick();
        check("abc_done_pulse", s_done, 0);

        // Continuation block of zeros with 0-3 cycle gaps
        s_blk = 1;
        tick();
        s_blk = 0;
        check("blk_chain_work", s_wout, ABC_DIGEST);
        check("blk_dv_clear", s_dv, 0);
        for (int i = 0; i < 64; i++) begin
            s_rv = 0;
            repeat (i % 4) tick();
            if (i == 10) check("gap_cnt10", s_cnt, 10);
            s_rv  = 1;
            s_win = '0;
            tick();
        end
        s_rv = 0;
        check("gap_ff_cnt", s_cnt, 64);
        check("gap_ff_busy", s_busy, 1);
        tick();
        check("gap_done", s_done, 1);
        check("gap_digest", s_dig, ABC_DIGEST);
        check("gap_dv", s_dv, 1);

        // Abort at round 30 with a simultaneous round_valid
        s_blk = 1;
        tick();
        s_blk = 0;
        for (int i = 0; i < 30; i++) begin
            s_rv = 1; s_win = pat_a;
            tick();
        end
        check("abort_pre_cnt", s_cnt, 30);
        s_abort = 1; s_rv = 1; s_win = pat_b;
        tick();
        s_abort = 0; s_rv = 0;
        check("abort_idle", s_busy, 0);
        check("abort_cnt", s_cnt, 0);
        check("abort_dv", s_dv, 0);
        check("abort_h", s_dig, ABC_DIGEST);
        check("abort_work", s_wout, pat_a);
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (s_done) done_seen++;
            tick();
        end
        check("abort_no_done", done_seen, 0);

        // start_blk after abort reloads the IV
        s_blk = 1;
        tick();
        s_blk = 0;
        check("blk_nochain_work", s_wout, IV256);
        check("blk_nochain_h", s_dig, IV256);
        s_abort = 1;
        tick();
        s_abort = 0;

        // start with abort: one LOAD cycle, nothing loaded
        s_rv = 1; s_win = pat_a;
        s_msg = 1; s_abort = 1;
        tick();
        s_msg = 0; s_abort = 0; s_rv = 0;
        check("load_busy", s_busy, 1);
        check("load_work", s_wout, IV256);
        tick();
        check("load_back_idle", s_busy, 0);
        check("load_cnt", s_cnt, 0);

        // 64-bit: one block with final work of +1 per word
        q_msg = 1;
        tick();
        q_msg = 0;
        for (int i = 0; i < 80; i++) begin
            q_rv  = 1;
            q_win = (i == 79) ? {8{64'h1}} : {8{64'(i)}};
            tick();
        end
        q_rv = 0;
        check("q_ff_cnt", q_cnt, 80);
        tick();
        check("q_done", q_done, 1);
        check("q_digest", q_dig, IV512_P1);

        // start_msg and start_blk together take the IV path
        q_msg = 1; q_blk = 1;
        tick();
        q_msg = 0; q_blk = 0;
        check("q_both_work", q_wout, IV512);
        check("q_both_h", q_dig, IV512);

        // A start while busy is ignored
        for (int i = 0; i < 5; i++) begin
            q_rv = 1; q_win = w5;
            tick();
        end
        q_rv = 0;
        q_msg = 1;
        tick();
        q_msg = 0;
        check("q_busy_start_work", q_wout, w5);
        check("q_busy_start_cnt", q_cnt, 5);

        // Asynchronous reset in the middle of a block
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy64", q_busy, 0);
        check("rst_mid_cnt64", q_cnt, 0);
        check("rst_mid_work64", q_wout, IV512);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_mid_done64", q_done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sha2_state_bank.md
Name: sha2_state_bank

Overview:
Parametrised SHA-2 hash-state and working-variable bank. Holds the chaining value H0..H7 and the working variables a..h for SHA-256 (WORD_W=32) or SHA-512 (WORD_W=64). Sequences one compression block: load, round updates, feed-forward add. Supports multi-block messages by chaining H across blocks. Sits between the message scheduler/round datapath and the digest output stage.

Parameters:
WORD_W, 32, word width; legal values 32 (SHA-256 IV set) and 64 (SHA-512 IV set); any other value is an elaboration error.
ROUNDS, 64, round updates per block; 64 for WORD_W=32, 80 for WORD_W=64.
CNT_W, $clog2(ROUNDS+1), round counter width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
start_msg  in  1  begin the first block of a new message.
start_blk  in  1  begin a continuation block; chains from the current H.
abort  in  1  synchronous abort of the block in flight.
round_valid  in  1  work_in holds the next round's a..h.
work_in  in  8*WORD_W  next working variables {a,b,c,d,e,f,g,h}, a in the MSBs.
work_out  out  8*WORD_W  current working variables, same packing.
round_cnt  out  CNT_W  round updates accepted in the current block.
busy  out  1  high in LOAD, ROUND and FEEDFWD.
blk_done  out  1  one-cycle pulse when H has been updated.
digest_valid  out  1  H holds a completed digest.
digest_out  out  8*WORD_W  {H0..H7}, H0 in the MSBs.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset: H and working registers = IV for WORD_W; state IDLE; round_cnt=0; busy=0; blk_done=0; digest_valid=0; chain_valid=0.
- FSM states: IDLE, LOAD, ROUND, FEEDFWD.
- IDLE:
  - start_msg: H <- IV, working <- IV, chain_valid <- 1, digest_valid <- 0, go to ROUND.
  - start_blk with chain_valid=1: working <- H, digest_valid <- 0, go to ROUND.
  - start_blk with chain_valid=0: treated exactly as start_msg.
  - start_msg and start_blk together: start_msg wins.
  - LOAD is the one-cycle path used when a start and abort arrive together; LOAD returns to IDLE without loading.
- Latency: work_out reflects the loaded values in the cycle after the start is accepted.
- Starts while busy=1 are ignored.
- ROUND:
  - Each cycle with round_valid=1: working <- work_in, round_cnt++.
  - When round ROUNDS is accepted (round_cnt reaches ROUNDS), go to FEEDFWD.
  - round_valid=0 stalls with no change.
  - round_valid outside ROUND is ignored.
- FEEDFWD (1 cycle):
  - Hi <- Hi + work_i mod 2^WORD_W, no carry between words.
  - Go to IDLE; blk_done=1 in the next cycle; digest_valid <- 1; round_cnt <- 0.
- abort (any state other than IDLE): go to IDLE; round_cnt=0; chain_valid=0; digest_valid=0; H unchanged; no blk_done. Abort has priority over round_valid in the same cycle.
- Reset mid-block: immediate return to reset values; no blk_done.
- digest_out is always driven from H; downstream qualifies it with digest_valid.

Optional Feature:
SHA2_TRUNC_EN:
- Defined: adds input mode_trunc (1 bit), sampled on start_msg only. mode_trunc=1 selects the SHA-224 IV (WORD_W=32) or the SHA-384 IV (WORD_W=64). While the mode is active, digest_out zeroes H7 (SHA-224) or H6..H7 (SHA-384). The selected mode holds across start_blk continuations.
- Undefined: no mode_trunc port; full IV set and full digest only.

Decomposition:
- Package sha2_pkg holds:
  - the IV constants for SHA-256, SHA-224, SHA-512 and SHA-384;
  - NUM_WORDS=8;
  - the state enum {IDLE, LOAD, ROUND, FEEDFWD};
  - a function selecting the IV by WORD_W and mode.
- One sub-module, sha2_feedfwd_add: 8 parallel WORD_W-bit modular adders, parametrised by WORD_W, producing the next H from H and the working variables.

Test Plan:
- Reset release, WORD_W=32 -> digest_out=6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19; digest_valid=0; busy=0.
- start_msg, 64 round_valid with final work_in=506e3058_d39a2165_04d24d6c_b85e2ce9_5ef50f24_fb121210_948d25b6_961f4894 -> blk_done 1 cycle after FEEDFWD; digest_out=ba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad; digest_valid=1.
- start_blk after the previous case -> work_out equals the previous digest 1 cycle later; 64 rounds of work_in=0 -> digest unchanged.
- Round stream with round_valid gaps of 0-3 cycles -> round_cnt counts only accepted updates; FEEDFWD entered exactly after round 64.
- abort at round_cnt=30 together with round_valid=1 -> IDLE, round_cnt=0, no blk_done, H unchanged, digest_valid=0; then start_blk -> IV loaded (chain_valid=0).
- WORD_W=64, ROUNDS=80: reset -> digest_out H0=6a09e667f3bcc908; start_msg plus start_blk together -> IV path taken; start while busy -> ignored.
